core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Shares the single data-memory port of top_processor between N_CORES matrix-multiplication cores.
- Sequences the job: waits for start_process, runs round-robin arbitration of core memory requests, then raises all_done once every core reports finished (drives the g-style completion flags).
- Sits between the cores' memory request interfaces and the data RAM.

Parameters:
- N_CORES, 3, number of requesting cores.
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- RD_LATENCY, 1, RAM read latency in cycles, counted from mem_addr valid to mem_rdata valid (range 1..4).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start_process  in  1  job start; a level sampled in IDLE.
- core_done  in  N_CORES  per-core finished level; sticky until rst.
- req  in  N_CORES  per-core access request level.
- we  in  N_CORES  per-core write enable; 0 means read.
- addr  in  N_CORES*ADDR_W  per-core address, core i at slice [i*ADDR_W +: ADDR_W].
- wdata  in  N_CORES*DATA_W  per-core write data, same slicing.
- gnt  out  N_CORES  one-hot one-cycle acceptance pulse.
- rvalid  out  N_CORES  one-hot one-cycle read-data-valid pulse.
- rdata  out  DATA_W  shared read data, qualified by rvalid.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- cores_run  out  1  enables the cores; high in RUN only.
- all_done  out  1  job complete; high in DONE.

Behaviour:
- Reset: state=IDLE; gnt, rvalid, mem_en, mem_we, cores_run, all_done = 0; rdata, mem_addr, mem_wdata = 0; round-robin pointer = N_CORES-1, so core 0 has first priority.
- FSM IDLE -> RUN when start_process=1.
- FSM RUN -> DRAIN when all core_done bits are 1.
- FSM DRAIN -> DONE when the read pipeline is empty.
- FSM DONE holds until rst. start_process is ignored outside IDLE.
- Arbitration happens only in RUN. Each cycle, candidates = req & ~gnt, which masks the core granted last cycle. The first candidate after the pointer, searched cyclically, wins.
- On a win, in the next cycle: gnt[w]=1, mem_en=1, mem_we=we[w], mem_addr and mem_wdata = that core's slices (all registered); pointer <- w.
- At most one grant per cycle, giving a throughput of 1 access per cycle.
- Requester handshake: hold req/we/addr/wdata stable until it sees gnt. Deassert req in the gnt cycle, or keep it high to request again; a held request is re-arbitrated no earlier than the cycle after gnt.
- Read return: a shift pipeline of depth RD_LATENCY carries {valid, core id}. rvalid[id]=1 and rdata=mem_rdata exactly RD_LATENCY cycles after the mem_en cycle. Writes produce no rvalid.
- DRAIN issues no new grants. It exits only when no read is in flight.
- cores_run = (state==RUN). all_done = (state==DONE).
- Requests asserted outside RUN stay pending; they are not granted and not lost.
- rst during RUN or DRAIN aborts immediately. In-flight reads are discarded, and no rvalid appears after rst.
- A core_done bit dropping is ignored, since the bits are sticky by contract.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds output grant_cnt (N_CORES*16). It holds a per-core count of gnt pulses, cleared by rst and saturating at 16'hFFFF, for load-balance checks.
- Undefined: the port and the counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package core_arb_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - localparams for default widths;
  - the function that computes the core-id width, clog2(N_CORES).
- Sub-module rr_picker: combinational round-robin picker. Inputs are candidates[N_CORES] and ptr; outputs are a one-hot winner plus an any flag. It is reused by other shared resources.

Test Plan:
- Reset, then start_process=1 for one cycle: cores_run=1 the next cycle; all outputs were 0 before.
- All 3 cores hold req (reads, addr 0x10/0x20/0x30): gnt order is core0, core1, core2, core0…; no core gets two consecutive grants while others wait. With RD_LATENCY=1, rvalid arrives 1 cycle after each mem_en with the matching rdata.
- Core1 writes 0xBEEF to 0x0042, then reads 0x0042: mem_we=1 on the first grant; the read returns rvalid[1] with rdata=0xBEEF.
- With RD_LATENCY=3, issue a read, then raise all core_done in the same cycle: state passes through DRAIN, rvalid arrives 3 cycles after mem_en, and all_done rises only after that.
- Assert rst two cycles after a read grant with RD_LATENCY=3: no rvalid, state=IDLE, and req stays ungranted until a new start_process.
- With ARB_STATS_EN, 30 back-to-back accesses per core: grant_cnt = 30 for each core.

Source files
------------

// File: rtl/core_arb_pkg.sv
// Shared types and helpers for the core memory arbiter and its round-robin picker.
package core_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int DEF_N_CORES    = 3;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_RD_LATENCY = 1;
  localparam int STAT_W         = 16;

  // Width of a core index; never narrower than one bit.
  function automatic int core_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set candidate strictly after ptr_i,
// searched cyclically, wins.
module rr_picker
  import core_arb_pkg::*;
#(
  parameter int N = DEF_N_CORES
) (
  input  logic [N-1:0]              candidates_i,
  input  logic [core_id_w(N)-1:0]   ptr_i,
  output logic [N-1:0]              winner_o,
  output logic                      any_o
);

  int   idx;
  logic found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!found && candidates_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one data-RAM port between N_CORES cores: job sequencing FSM, round-robin
// arbitration and read-return routing. Optional per-core grant counters under ARB_STATS_EN.
//
// Handshake: a core holds req/we/addr/wdata stable until it sees its one-cycle gnt pulse;
// it may drop req in that cycle or keep it high to request again (re-arbitrated no earlier
// than the following cycle). Read data returns as a one-cycle rvalid pulse with rdata.
module core_mem_arbiter
  import core_arb_pkg::*;
#(
  parameter int N_CORES    = DEF_N_CORES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_process,
  input  logic [N_CORES-1:0]          core_done,
  input  logic [N_CORES-1:0]          req,
  input  logic [N_CORES-1:0]          we,
  input  logic [N_CORES*ADDR_W-1:0]   addr,
  input  logic [N_CORES*DATA_W-1:0]   wdata,
  output logic [N_CORES-1:0]          gnt,
  output logic [N_CORES-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        cores_run,
  output logic                        all_done,
  output arb_state_e                  state_dbg
`ifdef ARB_STATS_EN
  ,
  output logic [N_CORES*STAT_W-1:0]   grant_cnt
`endif
);

  localparam int IDW = core_id_w(N_CORES);

  arb_state_e           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [N_CORES-1:0]   gnt_q, gnt_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [IDW-1:0]        pipe_id_q [RD_LATENCY];

  logic [N_CORES-1:0]   cand;
  logic [N_CORES-1:0]   win;
  logic                 win_any;
  logic [IDW-1:0]       win_id;
  logic                 rd_busy;

  // The core granted last cycle is masked so a held request cannot win twice in a row.
  assign cand = req & ~gnt_q;

  rr_picker #(
    .N (N_CORES)
  ) u_picker (
    .candidates_i (cand),
    .ptr_i        (ptr_q),
    .winner_o     (win),
    .any_o        (win_any)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (win[i]) win_id = IDW'(i);
    end
  end

  // A read is in flight while it is on the RAM port or in any stage before the last one.
  always_comb begin
    rd_busy = mem_en_q & ~mem_we_q;
    for (int k = 0; k < RD_LATENCY - 1; k++) begin
      rd_busy = rd_busy | pipe_vld_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_process) state_d = RUN;
      RUN:     if (&core_done)    state_d = DRAIN;
      DRAIN:   if (!rd_busy)      state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    if (state_q == RUN && win_any) begin
      gnt_d       = win;
      mem_en_d    = 1'b1;
      mem_we_d    = we[win_id];
      mem_addr_d  = addr[int'(win_id)*ADDR_W +: ADDR_W];
      mem_wdata_d = wdata[int'(win_id)*DATA_W +: DATA_W];
      ptr_d       = win_id;
      gnt_id_d    = win_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(N_CORES - 1);
      gnt_id_q    <= '0;
      gnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      gnt_q       <= gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Read-return shift line; reset flushes it so nothing returns after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) pipe_id_q[k] <= '0;
    end else begin
      pipe_vld_q[0] <= mem_en_q & ~mem_we_q;
      pipe_id_q[0]  <= gnt_id_q;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_id_q[k]  <= pipe_id_q[k-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (pipe_vld_q[RD_LATENCY-1]) begin
      rdata = mem_rdata;
      for (int i = 0; i < N_CORES; i++) begin
        if (pipe_id_q[RD_LATENCY-1] == IDW'(i)) rvalid[i] = 1'b1;
      end
    end
  end

  assign gnt       = gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cores_run = (state_q == RUN);
  assign all_done  = (state_q == DONE);
  assign state_dbg = state_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [N_CORES];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CORES; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else if (gnt_d[i] && cnt_q[i] != {STAT_W{1'b1}}) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_CORES; i++) begin
      grant_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed + randomized bench for core_mem_arbiter (RD_LATENCY=3) with a behavioural
// reference model of sequencing, round-robin order and read returns.
module tb_core_mem_arbiter;
  import core_arb_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start_process;
  logic [N-1:0]    core_done, req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic            mem_en, mem_we, cores_run, all_done;
  logic [AW-1:0]   mem_addr;
  arb_state_e      state_dbg;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  core_mem_arbiter #(
    .N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start_process(start_process), .core_done(core_done),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cores_run(cores_run), .all_done(all_done),
    .state_dbg(state_dbg)
`ifdef ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // requester-side stimulus state
  logic          c_req [N];
  logic          c_we  [N];
  logic [AW-1:0] c_addr[N];
  logic [DW-1:0] c_wd  [N];

  // RAM environment
  logic [DW-1:0] ram     [256];
  logic [DW-1:0] rd_pipe [LAT];

  // reference model
  int            m_phase;          // 0 idle, 1 run, 2 drain, 3 done
  int            m_last;
  logic [N-1:0]  m_gnt;
  logic          e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  int            m_cnt [N];
  logic [DW-1:0] ref_mem [256];
  int            rd_due [$];
  int            rd_id  [$];
  logic [DW-1:0] exp_q  [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req[i]             = c_req[i];
      we[i]              = c_we[i];
      addr[i*AW +: AW]   = c_addr[i];
      wdata[i*DW +: DW]  = c_wd[i];
    end
  endtask

  task automatic new_req(input int i);
    c_req[i]  = 1'b1;
    c_we[i]   = 1'($urandom_range(0, 1));
    c_addr[i] = AW'($urandom_range(0, 15));
    c_wd[i]   = DW'($urandom);
  endtask

  // Predict what must be visible after the next edge, from the rules of the job sequencer.
  task automatic predict();
    int old_phase;
    logic [N-1:0] cand;
    int w;
    if (rst) begin
      m_phase = 0; m_last = N - 1; m_gnt = '0; e_en = 0; e_we = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      rd_due.delete(); rd_id.delete(); exp_q.delete();
      return;
    end
    old_phase = m_phase;
    cand = req & ~m_gnt;
    m_gnt = '0; e_en = 0; e_we = 0;
    if (old_phase == 1) begin
      w = -1;
      for (int off = 1; off <= N; off++) begin
        if (w < 0 && cand[(m_last + off) % N]) w = (m_last + off) % N;
      end
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        e_en     = 1'b1;
        e_we     = we[w];
        e_addr   = addr[w*AW +: AW];
        e_wd     = wdata[w*DW +: DW];
        m_last   = w;
        if (m_cnt[w] < 65535) m_cnt[w]++;
        if (e_we) ref_mem[e_addr[7:0]] = e_wd;
        else begin
          rd_due.push_back(cyc + 1 + LAT);
          rd_id.push_back(w);
          exp_q.push_back(ref_mem[e_addr[7:0]]);
        end
      end
    end
    case (old_phase)
      0: if (start_process) m_phase = 1;
      1: if (&core_done)    m_phase = 2;
      2: if (rd_due.size() == 0) m_phase = 3;
      default: m_phase = 3;
    endcase
  endtask

  task automatic check_outputs();
    logic [N-1:0]  e_rv;
    logic [DW-1:0] e_rd;
    arb_state_e    e_st;
    e_rv = '0; e_rd = '0;
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      e_rv[rd_id[0]] = 1'b1;
      e_rd = exp_q[0];
      void'(rd_due.pop_front()); void'(rd_id.pop_front()); void'(exp_q.pop_front());
    end
    case (m_phase)
      0: e_st = IDLE;
      1: e_st = RUN;
      2: e_st = DRAIN;
      default: e_st = DONE;
    endcase
    chk("gnt", 64'(gnt), 64'(m_gnt));
    chk("mem_en", 64'(mem_en), 64'(e_en));
    if (e_en) begin
      chk("mem_we", 64'(mem_we), 64'(e_we));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    end
    chk("rvalid", 64'(rvalid), 64'(e_rv));
    if (e_rv != '0) chk("rdata", 64'(rdata), 64'(e_rd));
    chk("cores_run", 64'(cores_run), 64'(m_phase == 1));
    chk("all_done", 64'(all_done), 64'(m_phase == 3));
    chk("state", 64'(state_dbg), 64'(e_st));
  endtask

  // One clock: drive inputs, model the RAM at the edge, then check away from the edge.
  task automatic step();
    logic          cap_en, cap_we;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;
    apply();
    #0;
    predict();
    cap_en = mem_en; cap_we = mem_we; cap_a = mem_addr; cap_d = mem_wdata;
    @(posedge clk);
    for (int k = LAT - 1; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
    rd_pipe[0] = (cap_en && !cap_we) ? ram[cap_a[7:0]] : 16'hDEAD;
    if (cap_en && cap_we) ram[cap_a[7:0]] = cap_d;
    mem_rdata = rd_pipe[LAT-1];
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic do_access(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    c_req[i] = 1'b1; c_we[i] = w; c_addr[i] = a; c_wd[i] = d;
    for (int k = 0; k < 20; k++) begin
      step();
      if (m_gnt[i]) break;
    end
    chk("access_gnt", 64'(gnt[i]), 64'(1));
    c_req[i] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < 256; a++) begin
      ram[a]     = DW'(a * 16'h0101) ^ 16'h1234;
      ref_mem[a] = DW'(a * 16'h0101) ^ 16'h1234;
    end
    for (int i = 0; i < N; i++) begin
      c_req[i] = 0; c_we[i] = 0; c_addr[i] = '0; c_wd[i] = '0; m_cnt[i] = 0;
    end
    for (int k = 0; k < LAT; k++) rd_pipe[k] = '0;
    mem_rdata = '0;
    m_phase = 0; m_last = N - 1; m_gnt = '0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
    rst = 1'b1; start_process = 1'b0; core_done = '0;
    apply();

    // reset state
    idle_cycles(2);
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    rst = 1'b0;

    // requests raised in IDLE stay pending, then all three held reads rotate 0,1,2,0...
    for (int i = 0; i < N; i++) begin
      c_req[i] = 1'b1; c_we[i] = 1'b0; c_addr[i] = AW'((i + 1) * 16'h10);
    end
    idle_cycles(3);
    start_process = 1'b1;
    step();
    start_process = 1'b0;
    chk("run_after_start", 64'(cores_run), 64'(1));
    idle_cycles(9);
    for (int i = 0; i < N; i++) c_req[i] = 1'b0;
    idle_cycles(LAT + 2);

    // core1 write then read back
    do_access(1, 1'b1, 16'h0042, 16'hBEEF);
    do_access(1, 1'b0, 16'h0042, 16'h0000);
    idle_cycles(LAT + 2);

    // randomized traffic
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (c_req[i] && m_gnt[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i); else c_req[i] = 1'b0;
        end else if (!c_req[i] && $urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
      step();
    end
    for (int i = 0; i < N; i++) c_req[i] = 1'b0;
    idle_cycles(LAT + 2);

    // read issued together with the last core_done: DRAIN waits for its return
    c_req[2] = 1'b1; c_we[2] = 1'b0; c_addr[2] = 16'h0007;
    core_done = '1;
    step();
    c_req[2] = 1'b0;
    for (int k = 0; k < 20 && m_phase != 3; k++) step();
    chk("drain_to_done", 64'(all_done), 64'(1));
    start_process = 1'b1;
    core_done = 3'b010;
    idle_cycles(3);
    start_process = 1'b0;

    // abort with a read in flight
    rst = 1'b1; core_done = '0;
    step();
    rst = 1'b0;
    start_process = 1'b1;
    step();
    start_process = 1'b0;
    do_access(0, 1'b0, 16'h0005, 16'h0000);
    step();
    c_req[0] = 1'b1; c_addr[0] = 16'h0009;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_cycles(8);
    chk("abort_idle", 64'(state_dbg), 64'(IDLE));
    start_process = 1'b1;
    step();
    start_process = 1'b0;
    for (int k = 0; k < 10 && !m_gnt[0]; k++) step();
    chk("regrant_after_start", 64'(gnt[0]), 64'(1));
    c_req[0] = 1'b0;
    idle_cycles(LAT + 2);

    // back-to-back: 30 accesses per core
    rst = 1'b1;
    step();
    rst = 1'b0;
    start_process = 1'b1;
    step();
    start_process = 1'b0;
    for (int i = 0; i < N; i++) begin
      c_req[i] = 1'b1; c_we[i] = 1'(i == 1); c_addr[i] = AW'(i + 3); c_wd[i] = DW'(i);
    end
    for (int k = 0; k < 200 && (c_req[0] || c_req[1] || c_req[2]); k++) begin
      step();
      for (int i = 0; i < N; i++) if (m_gnt[i] && m_cnt[i] >= 30) c_req[i] = 1'b0;
    end
    idle_cycles(LAT + 2);
`ifdef ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      chk("grant_cnt_model", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
      chk("grant_cnt_30", 64'(grant_cnt[i*16 +: 16]), 64'(30));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
